decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, immediate/output data width (>=32, sign-extended beyond 32).
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of the PC carried alongside each instruction.
REQ-003 SHALL have parameter ENABLE_M, default 0; when 1, CAL_R with funct7=0000001 is legal.
REQ-004 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-005 SHALL have ports: in_valid input 1, in_ready output 1, in_inst input 32, in_pc input PC_WIDTH (upstream handshake).
REQ-006 SHALL have port flush input 1: discard all held instructions.
REQ-007 SHALL have ports: out_valid output 1, out_ready input 1, out_pc output PC_WIDTH.
REQ-008 SHALL have decoded output ports: opcode 7, funct3 3, funct7 7, rs1 5, rs2 5, rd 5, imm DATA_WIDTH signed, uses_rs1 1, uses_rs2 1, illegal 1.

Function
REQ-009 SHALL decode combinationally at the input and register the result; latency in_valid&in_ready to out_valid = 1 cycle.
REQ-010 SHALL hold decoded entries in a 2-entry skid buffer (main + skid); in_ready = skid slot empty, registered, not combinational from out_ready.
REQ-011 Transfer occurs on valid&ready; outputs SHALL stay stable while out_valid&!out_ready.
REQ-012 Out_ready low while main full and input accepted SHALL place the new entry in skid; in_ready drops the next cycle.
REQ-013 Simultaneous output pop and input push SHALL keep order: skid->main, new entry->skid or main as emptied; no loss, no duplication.
REQ-014 funct7 SHALL be inst[31:25] for CAL_R and for CAL_I shifts (funct3 001/101), else 0.
REQ-015 rs2 SHALL be inst[24:20] for BRANCH, STORE, CAL_R, else 0; uses_rs2 matches.
REQ-016 rs1 SHALL be inst[19:15] except LUI, AUIPC, JAL (rs1=0, uses_rs1=0).
REQ-017 rd SHALL be inst[11:7] except BRANCH, STORE (rd=0).
REQ-018 imm SHALL follow RV32I I/S/B/U/J formats per opcode, sign-extended to DATA_WIDTH; 0 for CAL_R.
REQ-019 illegal SHALL be 1 for unknown opcode, CAL_R funct7 not in {0000000, 0100000 for funct3 000/101, 0000001 if ENABLE_M}, or inst[1:0]!=11; an illegal entry still passes as valid.
REQ-020 flush SHALL empty both entries next edge, deassert out_valid, assert in_ready; in_valid during the flush cycle is dropped.
REQ-021 Decoded fields SHALL be 0 whenever out_valid=0.

Reset
REQ-022 rst SHALL asynchronously clear both entries: out_valid=0, in_ready=1 after release, all outputs 0.
REQ-023 rst asserted mid-stall SHALL discard held entries; no entry reappears after release.

Structure
REQ-024 Opcode constants (CAL_R, CAL_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) and funct7 codes SHALL live in the shared riscv definitions package.
REQ-025 Immediate generation SHALL be one sub-module, imm_gen (inst, opcode -> imm, parameter DATA_WIDTH); the buffer stays in decode_stage.

Verification
REQ-026 0x00500093 in, out_ready=1 -> next cycle opcode 0x13, rd=1, rs1=0, imm=5, rs2=0, illegal=0.
REQ-027 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, rd=0, imm=-4, uses_rs2=1.
REQ-028 0x0020A423 then 0x402081B3 with out_ready=0 two cycles -> in_ready=0 after second accept; on release outputs sw (imm=8, rd=0) then sub (funct7=0x20), in order.
REQ-029 0x027302B3 with ENABLE_M=0 -> illegal=1; ENABLE_M=1 -> illegal=0, funct7=0x01, rd=5.
REQ-030 Both entries full, flush pulse -> next cycle out_valid=0, in_ready=1; rst mid-stall -> out_valid=0 immediately, asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 opcode/funct7 constants and decoded-field record
package riscv_pkg;

  localparam logic [6:0] OP_CAL_R  = 7'b0110011;
  localparam logic [6:0] OP_CAL_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Width-independent decoded fields; imm and pc travel separately because they are parameterised
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       illegal;
  } dec_fields_t;

  function automatic logic is_known_opcode(input logic [6:0] op);
    return (op == OP_CAL_R) || (op == OP_CAL_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction, sign-extended to DATA_WIDTH
module imm_gen
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]                  inst,
  input  logic [6:0]                   opcode,
  output logic signed [DATA_WIDTH-1:0] imm
);

  logic [31:0] w_imm32;

  // Select the I/S/B/U/J layout by opcode; formats without an immediate yield zero
  always_comb begin
    w_imm32 = '0;
    case (opcode)
      OP_LOAD, OP_CAL_I, OP_JALR: w_imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                  w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                             inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:           w_imm32 = {inst[31:12], 12'b0};
      OP_JAL:                     w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                             inst[30:21], 1'b0};
      default:                    w_imm32 = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 decode with a two-entry skid buffer between upstream and downstream
module decode_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int ENABLE_M   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [PC_WIDTH-1:0]          in_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [6:0]                   opcode,
  output logic [2:0]                   funct3,
  output logic [6:0]                   funct7,
  output logic [4:0]                   rs1,
  output logic [4:0]                   rs2,
  output logic [4:0]                   rd,
  output logic signed [DATA_WIDTH-1:0] imm,
  output logic                         uses_rs1,
  output logic                         uses_rs2,
  output logic                         illegal
);

  dec_fields_t                  w_dec;
  logic signed [DATA_WIDTH-1:0] w_imm;
  logic [6:0]                   w_op;
  logic [2:0]                   w_f3;
  logic [6:0]                   w_f7;
  logic                         w_is_r;
  logic                         w_is_shift;
  logic                         w_r_legal;
  logic                         w_push;
  logic                         w_pop;

  dec_fields_t                  r_m_dec;
  dec_fields_t                  r_s_dec;
  logic signed [DATA_WIDTH-1:0] r_m_imm;
  logic signed [DATA_WIDTH-1:0] r_s_imm;
  logic [PC_WIDTH-1:0]          r_m_pc;
  logic [PC_WIDTH-1:0]          r_s_pc;
  logic                         r_m_valid;
  logic                         r_s_valid;

  assign w_op = in_inst[6:0];
  assign w_f3 = in_inst[14:12];
  assign w_f7 = in_inst[31:25];

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .inst   (in_inst),
    .opcode (w_op),
    .imm    (w_imm)
  );

  // Combinational field decode of the incoming instruction
  always_comb begin
    w_is_r     = (w_op == OP_CAL_R);
    w_is_shift = (w_op == OP_CAL_I) && ((w_f3 == 3'b001) || (w_f3 == 3'b101));
    w_r_legal  = (w_f7 == F7_BASE) ||
                 ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                 ((ENABLE_M != 0) && (w_f7 == F7_MULDIV));

    w_dec          = '0;
    w_dec.opcode   = w_op;
    w_dec.funct3   = w_f3;
    w_dec.funct7   = (w_is_r || w_is_shift) ? w_f7 : 7'd0;
    w_dec.uses_rs2 = (w_op == OP_BRANCH) || (w_op == OP_STORE) || w_is_r;
    w_dec.rs2      = w_dec.uses_rs2 ? in_inst[24:20] : 5'd0;
    w_dec.uses_rs1 = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
    w_dec.rs1      = w_dec.uses_rs1 ? in_inst[19:15] : 5'd0;
    w_dec.rd       = ((w_op == OP_BRANCH) || (w_op == OP_STORE)) ? 5'd0 : in_inst[11:7];
    w_dec.illegal  = !is_known_opcode(w_op) || (w_is_r && !w_r_legal) ||
                     (in_inst[1:0] != 2'b11);
  end

  // in_ready depends only on skid occupancy, so it never combinationally follows out_ready
  assign in_ready = !r_s_valid;
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = r_m_valid && out_ready;

  // Skid buffer: main feeds the output, skid catches the one entry accepted during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_dec   <= '0;
      r_s_dec   <= '0;
      r_m_imm   <= '0;
      r_s_imm   <= '0;
      r_m_pc    <= '0;
      r_s_pc    <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_s_valid) begin
        // Older skid entry moves up; in_ready was low so nothing new arrives this cycle
        r_m_valid <= 1'b1;
        r_m_dec   <= r_s_dec;
        r_m_imm   <= r_s_imm;
        r_m_pc    <= r_s_pc;
        r_s_valid <= 1'b0;
      end else if (w_push) begin
        r_m_valid <= 1'b1;
        r_m_dec   <= w_dec;
        r_m_imm   <= w_imm;
        r_m_pc    <= in_pc;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_m_valid) begin
        r_m_valid <= 1'b1;
        r_m_dec   <= w_dec;
        r_m_imm   <= w_imm;
        r_m_pc    <= in_pc;
      end else begin
        r_s_valid <= 1'b1;
        r_s_dec   <= w_dec;
        r_s_imm   <= w_imm;
        r_s_pc    <= in_pc;
      end
    end
  end

  // Present the main entry, forcing every field to zero while nothing is valid
  always_comb begin
    out_valid = r_m_valid;
    out_pc    = r_m_valid ? r_m_pc : '0;
    imm       = r_m_valid ? r_m_imm : '0;
    opcode    = r_m_valid ? r_m_dec.opcode : 7'd0;
    funct3    = r_m_valid ? r_m_dec.funct3 : 3'd0;
    funct7    = r_m_valid ? r_m_dec.funct7 : 7'd0;
    rs1       = r_m_valid ? r_m_dec.rs1 : 5'd0;
    rs2       = r_m_valid ? r_m_dec.rs2 : 5'd0;
    rd        = r_m_valid ? r_m_dec.rd : 5'd0;
    uses_rs1  = r_m_valid && r_m_dec.uses_rs1;
    uses_rs2  = r_m_valid && r_m_dec.uses_rs2;
    illegal   = r_m_valid && r_m_dec.illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (32-bit base and 64-bit M-enabled instances)
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;

  logic               a_in_ready, a_out_valid, a_uses_rs1, a_uses_rs2, a_illegal;
  logic [31:0]        a_out_pc;
  logic [6:0]         a_opcode, a_funct7;
  logic [2:0]         a_funct3;
  logic [4:0]         a_rs1, a_rs2, a_rd;
  logic signed [31:0] a_imm;

  logic               b_in_ready, b_out_valid, b_uses_rs1, b_uses_rs2, b_illegal;
  logic [31:0]        b_out_pc;
  logic [6:0]         b_opcode, b_funct7;
  logic [2:0]         b_funct3;
  logic [4:0]         b_rs1, b_rs2, b_rd;
  logic signed [63:0] b_imm;

  decode_stage #(.DATA_WIDTH(32), .PC_WIDTH(32), .ENABLE_M(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7),
    .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .imm(a_imm), .uses_rs1(a_uses_rs1),
    .uses_rs2(a_uses_rs2), .illegal(a_illegal)
  );

  decode_stage #(.DATA_WIDTH(64), .PC_WIDTH(32), .ENABLE_M(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .imm(b_imm), .uses_rs1(b_uses_rs1),
    .uses_rs2(b_uses_rs2), .illegal(b_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    longint      imm;
    logic        u1;
    logic        u2;
    logic        ill_a;
    logic        ill_b;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input longint imm, input logic u1, input logic u2,
                              input logic ill_a, input logic ill_b, input logic [31:0] pc);
    exp_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
    e.u1 = u1; e.u2 = u2; e.ill_a = ill_a; e.ill_b = ill_b; e.pc = pc;
    return e;
  endfunction

  task automatic cmp_entry(input exp_t e, input string tag);
    chk({tag, " opcode"}, a_opcode, e.op);
    chk({tag, " funct3"}, a_funct3, e.f3);
    chk({tag, " funct7"}, a_funct7, e.f7);
    chk({tag, " rs1"}, a_rs1, e.rs1);
    chk({tag, " rs2"}, a_rs2, e.rs2);
    chk({tag, " rd"}, a_rd, e.rd);
    chk({tag, " imm"}, a_imm, e.imm);
    chk({tag, " uses_rs1"}, a_uses_rs1, e.u1);
    chk({tag, " uses_rs2"}, a_uses_rs2, e.u2);
    chk({tag, " illegal"}, a_illegal, e.ill_a);
    chk({tag, " pc"}, a_out_pc, e.pc);
    chk({tag, " m.out_valid"}, b_out_valid, 1);
    chk({tag, " m.imm64"}, b_imm, e.imm);
    chk({tag, " m.illegal"}, b_illegal, e.ill_b);
    chk({tag, " m.funct7"}, b_funct7, e.f7);
    chk({tag, " m.rd"}, b_rd, e.rd);
  endtask

  // Monitor: every presented output is checked against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && a_out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected out_valid", 1, 0);
      end else begin
        cmp_entry(q[0], out_ready ? "pop" : "stall");
        if (out_ready) q.delete(0);
      end
    end
  end

  // Holds in_inst until accepted; the expectation is queued on the accepting cycle
  task automatic send(input logic [31:0] inst, input exp_t e);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = e.pc;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = a_in_ready;
      if (acc) q.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send timeout", 0, 1);
  endtask

  exp_t e_addi, e_beq, e_lui, e_jal, e_srai, e_lw, e_bad, e_sllalt, e_mul, e_sw, e_sub;

  initial begin
    e_addi   = mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,  5,          1, 0, 0, 0, 32'h100);
    e_beq    = mk(7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, -4,          1, 1, 0, 0, 32'h104);
    e_lui    = mk(7'h37, 3'd5, 7'h00, 5'd0, 5'd0, 5'd1, 64'h12345000, 0, 0, 0, 0, 32'h108);
    e_jal    = mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,  8,          0, 0, 0, 0, 32'h10C);
    e_srai   = mk(7'h13, 3'd5, 7'h20, 5'd6, 5'd0, 5'd5,  1027,       1, 0, 0, 0, 32'h110);
    e_lw     = mk(7'h03, 3'd2, 7'h00, 5'd2, 5'd0, 5'd4, -8,          1, 0, 0, 0, 32'h114);
    e_bad    = mk(7'h7F, 3'd7, 7'h00, 5'd31, 5'd0, 5'd31, 0,         1, 0, 1, 1, 32'h118);
    e_sllalt = mk(7'h33, 3'd1, 7'h20, 5'd1, 5'd2, 5'd2,  0,          1, 1, 1, 1, 32'h11C);
    e_mul    = mk(7'h33, 3'd0, 7'h01, 5'd6, 5'd7, 5'd5,  0,          1, 1, 1, 0, 32'h120);
    e_sw     = mk(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0,  8,          1, 1, 0, 0, 32'h200);
    e_sub    = mk(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3,  0,          1, 1, 0, 0, 32'h204);

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", a_out_valid, 0);
    chk("reset opcode", a_opcode, 0);
    chk("reset imm", a_imm, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset in_ready", a_in_ready, 1);
    chk("post-reset out_valid", a_out_valid, 0);
    chk("post-reset rd", a_rd, 0);

    // Streaming with out_ready high, plus one-cycle latency
    out_ready = 1'b1;
    send(32'h00500093, e_addi);
    chk("latency out_valid", a_out_valid, 1);
    send(32'hFE208EE3, e_beq);
    send(32'h123450B7, e_lui);
    send(32'h008000EF, e_jal);
    send(32'h40335293, e_srai);
    send(32'hFF812203, e_lw);
    send(32'hFFFFFFFF, e_bad);
    send(32'h40209133, e_sllalt);
    send(32'h027302B3, e_mul);
    repeat (2) @(posedge clk);
    #1;
    chk("idle out_valid", a_out_valid, 0);
    chk("idle illegal zero", a_illegal, 0);

    // Stall: second accept goes to skid and drops in_ready
    out_ready = 1'b0;
    send(32'h0020A423, e_sw);
    send(32'h402081B3, e_sub);
    chk("skid full in_ready", a_in_ready, 0);
    chk("skid full out_valid", a_out_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00500093, mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 5, 1, 0, 0, 0, 32'h208));
    repeat (3) @(posedge clk);
    #1;

    // Flush with both entries full; concurrent input is dropped
    out_ready = 1'b0;
    send(32'h123450B7, e_lui);
    send(32'h008000EF, e_jal);
    chk("pre-flush in_ready", a_in_ready, 0);
    in_valid = 1'b1;
    in_inst  = 32'h00500093;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush out_valid", a_out_valid, 0);
    chk("flush in_ready", a_in_ready, 1);
    chk("flush opcode zero", a_opcode, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush no reappear", a_out_valid, 0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(32'hFE208EE3, e_beq);
    send(32'h0020A423, e_sw);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", a_out_valid, 0);
    chk("async rst m.out_valid", b_out_valid, 0);
    chk("async rst in_ready", a_in_ready, 1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst no reappear", a_out_valid, 0);
    chk("rst in_ready", a_in_ready, 1);

    // Recovery after reset
    send(32'h402081B3, e_sub);
    send(32'h027302B3, e_mul);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain queue empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
